bit_stuff_tx: RTL

Serial frame transmitter implementing the insertion side of the five-consecutive-ones rule: parallel bytes go in, one bit per clock comes out. Inside a frame a 0 is inserted after every run of five data 1s, so the serial stream never carries six 1s except in flags and aborts. Frames are delimited by flags, and the line carries continuous flags when idle. The block drives the serial line that our five-ones detectors and receivers monitor.

---
 rtl/bit_stuff_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bit_stuff_tx.sv
// bit_stuff_tx: serial frame transmitter with zero-bit insertion.
// Parallel bytes are shifted out LSB first, one bit per clk. Inside a frame a 0
// is inserted after every RUN_LEN consecutive data 1s. Frames are delimited by
// FLAG, the idle line repeats FLAG, and an underrun sends ABORT_LEN ones.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   in_data       byte to transmit, LSB first
//   in_last       in_data is the final byte of the frame
//   in_valid      in_data / in_last are valid
//   in_ready      byte is taken at this edge if in_valid=1 (state decode only)
//   tx_bit        registered serial line bit
//   stuffed       registered; current tx_bit is an inserted 0
//   frame_active  registered; current tx_bit is a data or stuffed bit
//   abort         registered; current tx_bit is an abort one
module bit_stuff_tx #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] FLAG      = DATA_W'(8'h7E),
    parameter int unsigned       RUN_LEN   = 5,
    parameter int unsigned       ABORT_LEN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              stuffed,
    output logic              frame_active,
    output logic              abort
);

    localparam int unsigned IDX_MAX = (DATA_W > ABORT_LEN) ? DATA_W : ABORT_LEN;
    localparam int unsigned IDX_W   = $clog2(IDX_MAX);
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1);

    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] ABORT_END = IDX_W'(ABORT_LEN - 1);
    localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(RUN_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CLOSE = 2'd2,
        S_ABORT = 2'd3
    } state_e;

    // State describes the bit currently on tx_bit.
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               stuff_q, stuff_d;
    logic [DATA_W-1:0]  byte_q, byte_d;
    logic               last_q, last_d;
    logic               tx_bit_q, tx_bit_d;
    logic               frame_active_q, frame_active_d;
    logic               abort_q, abort_d;

    logic run_done_c;
    logic boundary_c;
    logic xfer_c;

    // A data 1 just completed a run: the next cycle must be a stuffed 0.
    assign run_done_c = (state_q == S_DATA) && !stuff_q && (ones_q == RUN_MAX);

    // Last cycle of the current flag or byte (a trailing stuffed 0 belongs to the byte).
    always_comb begin
        boundary_c = 1'b0;
        case (state_q)
            S_IDLE, S_CLOSE: boundary_c = (idx_q == LAST_BIT);
            S_DATA:          boundary_c = (idx_q == LAST_BIT) && !run_done_c;
            default:         boundary_c = 1'b0;
        endcase
    end

    assign in_ready = boundary_c && !((state_q == S_DATA) && last_q);
    assign xfer_c   = in_ready && in_valid;

    // Next-state: slot sequencing, stuffing and run counting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        stuff_d = 1'b0;
        byte_d  = byte_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE, S_CLOSE: begin
                if (boundary_c) begin
                    idx_d = '0;
                    if (xfer_c) begin
                        // Counter restarts with the first bit of the new frame.
                        state_d = S_DATA;
                        byte_d  = in_data;
                        last_d  = in_last;
                        ones_d  = in_data[0] ? CNT_W'(1) : '0;
                    end else begin
                        state_d = S_IDLE;
                        ones_d  = '0;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DATA: begin
                if (run_done_c) begin
                    // Insert a 0; the shift index holds.
                    stuff_d = 1'b1;
                    ones_d  = '0;
                end else if (boundary_c) begin
                    idx_d = '0;
                    if (last_q) begin
                        state_d = S_CLOSE;
                        ones_d  = '0;
                    end else if (xfer_c) begin
                        // Run count carries across byte boundaries.
                        byte_d = in_data;
                        last_d = in_last;
                        ones_d = in_data[0] ? (ones_q + CNT_W'(1)) : '0;
                    end else begin
                        state_d = S_ABORT;
                        ones_d  = '0;
                    end
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    ones_d = byte_q[idx_d] ? (ones_q + CNT_W'(1)) : '0;
                end
            end
            S_ABORT: begin
                if (idx_q == ABORT_END) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                ones_d  = '0;
            end
        endcase
    end

    // Registered line outputs derived from the next slot contents.
    always_comb begin
        tx_bit_d       = FLAG[idx_d];
        frame_active_d = 1'b0;
        abort_d        = 1'b0;
        case (state_d)
            S_DATA: begin
                tx_bit_d       = stuff_d ? 1'b0 : byte_d[idx_d];
                frame_active_d = 1'b1;
            end
            S_ABORT: begin
                tx_bit_d = 1'b1;
                abort_d  = 1'b1;
            end
            default: tx_bit_d = FLAG[idx_d];
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            ones_q         <= '0;
            stuff_q        <= 1'b0;
            byte_q         <= '0;
            last_q         <= 1'b0;
            tx_bit_q       <= FLAG[0];
            frame_active_q <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ones_q         <= ones_d;
            stuff_q        <= stuff_d;
            byte_q         <= byte_d;
            last_q         <= last_d;
            tx_bit_q       <= tx_bit_d;
            frame_active_q <= frame_active_d;
            abort_q        <= abort_d;
        end
    end

    assign tx_bit       = tx_bit_q;
    assign stuffed      = stuff_q;
    assign frame_active = frame_active_q;
    assign abort        = abort_q;

endmodule
